// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment scan driver and related display
// blocks:
//   - scan_state_e : scan FSM states (IDLE / SHOW / GAP)
//   - HEX7_TABLE   : hex nibble -> {A,B,C,D,E,F,G} pattern, active-high
//   - FIELD_*      : bit positions of the logical output word {SEL, A..G, DP},
//                    shared with the downstream pin-remap stage
//   - cnt_width()  : counter width helper ($clog2 with a floor of 1)
// -----------------------------------------------------------------------------
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } scan_state_e;

    // Index = nibble value; bit 6 is segment A, bit 0 is segment G.
    localparam logic [6:0] HEX7_TABLE [16] = '{
        7'b1111110, // 0
        7'b0110000, // 1
        7'b1101101, // 2
        7'b1111001, // 3
        7'b0110011, // 4
        7'b1011011, // 5
        7'b1011111, // 6
        7'b1110000, // 7
        7'b1111111, // 8
        7'b1111011, // 9
        7'b1110111, // A
        7'b0011111, // b
        7'b1001110, // C
        7'b0111101, // d
        7'b1001111, // E
        7'b1000111  // F
    };

    // Logical output word {SEL, A, B, C, D, E, F, G, DP}, DP at bit 0.
    localparam int FIELD_DP      = 0;
    localparam int FIELD_G       = 1;
    localparam int FIELD_F       = 2;
    localparam int FIELD_E       = 3;
    localparam int FIELD_D       = 4;
    localparam int FIELD_C       = 5;
    localparam int FIELD_B       = 6;
    localparam int FIELD_A       = 7;
    localparam int FIELD_SEL_LSB = 8;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 1) ? int'($clog2(max_val)) : 1;
    endfunction

endpackage

// File: rtl/seg_hex7.sv
// -----------------------------------------------------------------------------
// seg_hex7
// Combinational hex nibble to seven-segment decoder (active-high output).
// Ports:
//   nibble_i [3:0] : hex value to display
//   blank_i        : 1 forces all segments off
//   seg_o    [6:0] : {A,B,C,D,E,F,G}, A at bit 6
// -----------------------------------------------------------------------------
module seg_hex7
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    assign seg_o = blank_i ? 7'b0000000 : HEX7_TABLE[nibble_i];

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed seven-segment display driver. Per-digit nibbles, decimal
// points and blank flags are captured into a pending bank on `load` and moved
// to the active bank at a frame boundary, so a frame never mixes old and new
// data. One digit is lit at a time for REFRESH_DIV cycles.
//
// Optional build macro:
//   SEG_DEADTIME_EN : insert DEADTIME all-off cycles between digits (GAP state).
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   en                 : scan enable, 0 forces outputs inactive
//   load               : strobe capturing digits/dp/blank into the pending bank
//   digits[4*N-1:0]    : hex nibble per digit, digit 0 at [3:0]
//   dp[N-1:0]          : decimal point per digit
//   blank[N-1:0]       : suppress segments and DP of a digit
//   sel[N-1:0]         : one-hot digit select (polarity applied)
//   seg[6:0]           : {A..G}, A at bit 6 (polarity applied)
//   seg_dp             : decimal point (polarity applied)
//   frame_done         : one-cycle pulse when the digit index wraps to 0
// -----------------------------------------------------------------------------
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned DEADTIME       = 64,
    parameter bit          SEL_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   sel,
    output logic [6:0]              seg,
    output logic                    seg_dp,
    output logic                    frame_done
);

    localparam int unsigned IDX_W = cnt_width(NUM_DIGITS);
    localparam int unsigned DIV_W = cnt_width(REFRESH_DIV);

    // Inactive levels double as XOR masks for the final polarity stage.
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW}};
    localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;

    scan_state_e             state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [DIV_W-1:0]        div_cnt_q;
    logic                    frame_done_q;
    logic [NUM_DIGITS-1:0]   sel_q;
    logic [6:0]              seg_q;
    logic                    dp_q;

    logic [4*NUM_DIGITS-1:0] pend_digits_q, act_digits_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q, act_dp_q;
    logic [NUM_DIGITS-1:0]   pend_blank_q, act_blank_q;
    logic                    pend_v_q;

    logic [3:0]              act_nib [NUM_DIGITS];
    logic [6:0]              dec_seg;
    logic                    div_tc, idx_last, advance, swap, lit;
    logic [IDX_W-1:0]        idx_next;
    logic [NUM_DIGITS-1:0]   sel_d;
    logic [6:0]              seg_d;
    logic                    dp_d;

`ifdef SEG_DEADTIME_EN
    localparam int unsigned GAP_W = cnt_width(DEADTIME);
    logic [GAP_W-1:0] gap_cnt_q;
    logic             gap_tc;
    assign gap_tc  = (gap_cnt_q == GAP_W'(DEADTIME - 1));
    assign advance = en && (state_q == ST_GAP) && gap_tc;
`else
    logic unused_deadtime;
    assign unused_deadtime = ^DEADTIME;
    assign advance = en && (state_q == ST_SHOW) && div_tc;
`endif

    assign div_tc   = (div_cnt_q == DIV_W'(REFRESH_DIV - 1));
    assign idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign idx_next = idx_last ? '0 : idx_q + IDX_W'(1);
    // Bank swap rides on the same edge that wraps the index.
    assign swap     = advance && idx_last;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
        assign act_nib[g] = act_digits_q[4*g +: 4];
    end

    seg_hex7 u_hex7 (
        .nibble_i (act_nib[idx_q]),
        .blank_i  (act_blank_q[idx_q]),
        .seg_o    (dec_seg)
    );

    // Output next-state is built from the registered idx/state, so select and
    // segments both lag the index by one cycle and change on the same edge.
    // `en` is folded in so a falling enable blanks on the very next edge.
    always_comb begin
        lit   = en && (state_q == ST_SHOW);
        sel_d = (lit ? (NUM_DIGITS'(1) << idx_q) : '0) ^ SEL_OFF;
        seg_d = (lit ? dec_seg : 7'b0000000) ^ SEG_OFF;
        dp_d  = (lit & act_dp_q[idx_q] & ~act_blank_q[idx_q]) ^ DP_OFF;
    end

    // Scan FSM, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            div_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            sel_q        <= SEL_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
`ifdef SEG_DEADTIME_EN
            gap_cnt_q    <= '0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            sel_q        <= sel_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            if (!en) begin
                state_q   <= ST_IDLE;
                idx_q     <= '0;
                div_cnt_q <= '0;
`ifdef SEG_DEADTIME_EN
                gap_cnt_q <= '0;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_SHOW;
                    ST_SHOW: begin
                        if (div_tc) begin
                            div_cnt_q <= '0;
`ifdef SEG_DEADTIME_EN
                            state_q   <= ST_GAP;
`else
                            idx_q        <= idx_next;
                            frame_done_q <= idx_last;
`endif
                        end else begin
                            div_cnt_q <= div_cnt_q + DIV_W'(1);
                        end
                    end
`ifdef SEG_DEADTIME_EN
                    ST_GAP: begin
                        if (gap_tc) begin
                            gap_cnt_q    <= '0;
                            idx_q        <= idx_next;
                            frame_done_q <= idx_last;
                            state_q      <= ST_SHOW;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                        end
                    end
`endif
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Pending/active banks. A load coinciding with a swap lands in pending
    // after the old pending has been copied, so it shows one frame later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= '0;
            pend_v_q      <= 1'b0;
            act_digits_q  <= '0;
            act_dp_q      <= '0;
            act_blank_q   <= '0;
        end else begin
            if (swap && pend_v_q) begin
                act_digits_q <= pend_digits_q;
                act_dp_q     <= pend_dp_q;
                act_blank_q  <= pend_blank_q;
            end
            if (load) begin
                pend_digits_q <= digits;
                pend_dp_q     <= dp;
                pend_blank_q  <= blank;
            end
            pend_v_q <= load | (pend_v_q & ~swap);
        end
    end

    assign sel        = sel_q;
    assign seg        = seg_q;
    assign seg_dp     = dp_q;
    assign frame_done = frame_done_q;

endmodule
